pipelined_cla_adder: RTL and testbench

- Parametrised successor to the team's registered 4-bit CLA adder.
- Computes WIDTH-bit add/subtract through a pipeline of CHUNK-bit carry-lookahead slices. Each slice is registered, and the inter-slice carry is passed forward in a register.
- Operands are registered on entry, matching the current adder's registered-input style.
- Adds a valid/ready handshake with backpressure, subtract mode, carry-in, carry-out and signed-overflow flags. Used as the datapath adder wherever a wide, high-fmax add is needed.

---
 rtl/pipelined_cla_adder.sv | 142 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Purpose : WIDTH-bit add/subtract built from a chain of registered CHUNK-bit carry-lookahead slices.
// Latency : STAGES = WIDTH/CHUNK cycles from acceptance to out_valid; one result per cycle when out_ready is held high.
// Backpr. : single global advance (!out_valid || out_ready); when it is low every stage holds and in_ready is low.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (a, b, cin, sub)
//   a, b                    operands, unsigned or two's complement
//   cin                     carry-in, add mode only
//   sub                     0: a+b+cin, 1: a-b (cin ignored)
//   out_valid / out_ready   result handshake (sum, cout, ovf)
//   sum                     WIDTH-bit result
//   cout                    carry out of the MSB (sub mode: 1 = no borrow)
//   ovf                     two's-complement overflow
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  // One CLA block. Each carry is formed directly from the generate/propagate
  // terms and the slice carry-in, so no carry depends on another carry.
  function automatic logic [CHUNK:0] cla(input logic [CHUNK-1:0] x,
                                         input logic [CHUNK-1:0] y,
                                         input logic             ci);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      // carry-in propagated through p[i:0]
      term = ci;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      // generate at bit j propagated through p[i:j+1]
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[CHUNK], p ^ c[CHUNK-1:0]};
  endfunction

  logic adv;

  // Stage 0 is the operand entry register; stages 1..STAGES are the slices.
  // Operands are only needed up to the last slice. Each stage keeps the full
  // operand word; the lower chunks already consumed are simply never read.
  logic [WIDTH-1:0] opa_q [0:STAGES-1];
  logic [WIDTH-1:0] opb_q [0:STAGES-1];
  logic [WIDTH-1:0] sum_q [0:STAGES];
  logic             cy_q  [0:STAGES];
  logic             vld_q [0:STAGES];
  logic             sa_q  [0:STAGES];
  logic             sb_q  [0:STAGES];

  logic [CHUNK:0]   slice_res [1:STAGES];
  logic [WIDTH-1:0] sum_nxt   [1:STAGES];

  assign adv      = !vld_q[STAGES] || out_ready;
  assign in_ready = rst_n && adv;

  // Slice s fills bits [s*CHUNK-1 : (s-1)*CHUNK]; lower result bits ride along.
  always_comb begin
    for (int s = 1; s <= STAGES; s++) begin
      slice_res[s] = cla(opa_q[s-1][(s-1)*CHUNK +: CHUNK],
                         opb_q[s-1][(s-1)*CHUNK +: CHUNK],
                         cy_q[s-1]);
      sum_nxt[s] = sum_q[s-1];
      sum_nxt[s][(s-1)*CHUNK +: CHUNK] = slice_res[s][CHUNK-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= STAGES; s++) begin
        sum_q[s] <= '0;
        cy_q[s]  <= 1'b0;
        vld_q[s] <= 1'b0;
        sa_q[s]  <= 1'b0;
        sb_q[s]  <= 1'b0;
      end
      for (int s = 0; s < STAGES; s++) begin
        opa_q[s] <= '0;
        opb_q[s] <= '0;
      end
    end else if (adv) begin
      // Subtract is a + ~b + 1, so the carry-in is forced high in sub mode.
      // Data is captured unconditionally; a bubble is marked by vld_q alone.
      vld_q[0] <= in_valid;
      opa_q[0] <= a;
      opb_q[0] <= sub ? ~b : b;
      cy_q[0]  <= sub | cin;
      sa_q[0]  <= a[WIDTH-1];
      sb_q[0]  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      sum_q[0] <= '0;
      for (int s = 1; s <= STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        sa_q[s]  <= sa_q[s-1];
        sb_q[s]  <= sb_q[s-1];
        sum_q[s] <= sum_nxt[s];
        cy_q[s]  <= slice_res[s][CHUNK];
      end
      for (int s = 1; s < STAGES; s++) begin
        opa_q[s] <= opa_q[s-1];
        opb_q[s] <= opb_q[s-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES];
  assign sum       = sum_q[STAGES];
  assign cout      = cy_q[STAGES];
  assign ovf       = (sa_q[STAGES] == sb_q[STAGES]) && (sum_q[STAGES][WIDTH-1] != sa_q[STAGES]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Purpose : directed bench for pipelined_cla_adder (WIDTH=16, CHUNK=4) with an arithmetic reference queue.
// Latency : expects results 4 edges after acceptance, one per cycle when streaming.
// Backpr. : exercises an out_ready stall and checks the frozen output and in_ready.
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int errors  = 0;
  int nchecks = 0;
  int cyc     = 0;

  logic [17:0] exp_q [$];   // {cout, ovf, sum} in acceptance order
  logic [15:0] log_sum [$];
  int          log_cyc [$];

  logic [15:0] bp_exp [6] = '{16'h0101, 16'h0212, 16'h0323, 16'h0434, 16'h0545, 16'h0656};

  pipelined_cla_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic for the result and carry, signed integer
  // range test for overflow.
  function automatic logic [17:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                        input logic icin, input logic isub);
    logic [16:0] full;
    int          sres;
    if (isub) begin
      full = {1'b0, ia} - {1'b0, ib} + 17'h10000;
      sres = int'($signed(ia)) - int'($signed(ib));
    end else begin
      full = {1'b0, ia} + {1'b0, ib} + {16'h0, icin};
      sres = int'($signed(ia)) + int'($signed(ib)) + int'(icin);
    end
    return {full[16], (sres > 32767 || sres < -32768), full[15:0]};
  endfunction

  // Every-cycle compare against the reference queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 0);
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          chk("mon_sum", sum, exp_q[0][15:0]);
          chk("mon_ovf", ovf, exp_q[0][16]);
          chk("mon_cout", cout, exp_q[0][17]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            log_sum.push_back(sum);
            log_cyc.push_back(cyc);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic run_one(input string nm, input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic isub,
                         input logic [15:0] es, input logic ec, input logic eo);
    int edges;
    @(posedge clk); #1;
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    @(negedge clk);
    while (!out_valid && edges < 10) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, edges, 4);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, ovf, eo);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_one_cycle"}, out_valid, 0);
  endtask

  task automatic run_stream();
    int e0;
    log_sum.delete(); log_cyc.delete();
    @(posedge clk); #1;
    e0 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      a = 16'(i); b = 16'(16'h1000 * i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("stream_count", log_sum.size(), 8);
    for (int i = 0; i < 8 && i < log_sum.size(); i++) begin
      chk("stream_sum", log_sum[i], 16'(16'h1001 * i));
      chk("stream_cycle", log_cyc[i], e0 + 4 + i);
    end
  endtask

  task automatic run_backpressure();
    int          nd;
    int          nc;
    logic        ok;
    logic [15:0] held;
    log_sum.delete(); log_cyc.delete();
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          a = 16'(16'h0111 * i); b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
          nd = 0;
          do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; nd++;
          end while (!ok && nd < 50);
          chk("bp_accept_bound", ok, 1);
        end
        in_valid = 1'b0;
      end
      begin
        nc = 0;
        while (!out_valid && nc < 50) begin
          @(posedge clk); #1; nc++;
        end
        chk("bp_first_valid", out_valid, 1);
        out_ready = 1'b0;
        held = sum;
        repeat (5) begin
          @(negedge clk);
          chk("bp_stall_in_ready", in_ready, 0);
          chk("bp_stall_valid", out_valid, 1);
          chk("bp_stall_sum", sum, held);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("bp_count", log_sum.size(), 6);
    for (int i = 0; i < 6 && i < log_sum.size(); i++) chk("bp_order", log_sum[i], bp_exp[i]);
  endtask

  task automatic run_reset_midflight();
    logic seen;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      a = 16'(16'h1234 + i); b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_sum", sum, 16'h2345);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("mid_no_stale_valid", seen, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, nchecks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_release_in_ready", in_ready, 1);

    run_one("add_simple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_one("add_chain",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_stream();
    run_backpressure();
    run_reset_midflight();
    run_one("post_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("model_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
